// File: rtl/snitch_wrr_scheduler_pkg.sv
// Shared payload types for the weighted
// round-robin data-port scheduler.
package snitch_wrr_scheduler_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        write;
  } dreq_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } dresp_t;

endpackage

// File: rtl/snitch_wrr_pick.sv
// Rotating-priority find-first: returns the
// first set mask bit searched from ptr_i+1.
module snitch_wrr_pick #(
  parameter int unsigned NrPorts = 4
) (
  input  logic [NrPorts-1:0]         mask_i,
  input  logic [$clog2(NrPorts)-1:0] ptr_i,
  output logic [$clog2(NrPorts)-1:0] idx_o,
  output logic                       valid_o
);

  localparam int unsigned IdxWidth =
    $clog2(NrPorts);

  logic [IdxWidth-1:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NrPorts; k++) begin
      cand = IdxWidth'(
        (32'(ptr_i) + k) % NrPorts);
      if (!valid_o && mask_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snitch_wrr_scheduler.sv
// Weighted round-robin scheduler with per-port
// outstanding caps and in-order response routing.
module snitch_wrr_scheduler
  import snitch_wrr_scheduler_pkg::*;
#(
  parameter int unsigned NrPorts        = 4,
  parameter type         req_t          = dreq_t,
  parameter type         resp_t         = dresp_t,
  parameter int unsigned WeightWidth    = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned RespDepth      = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [NrPorts-1:0][WeightWidth-1:0]
               weight_i,
  input  req_t [NrPorts-1:0] req_payload_i,
  input  logic [NrPorts-1:0] req_valid_i,
  output logic [NrPorts-1:0] req_ready_o,
  output resp_t [NrPorts-1:0] resp_payload_o,
  output logic [NrPorts-1:0] resp_last_o,
  output logic [NrPorts-1:0] resp_valid_o,
  input  logic [NrPorts-1:0] resp_ready_i,
  output req_t req_payload_o,
  output logic req_valid_o,
  input  logic req_ready_i,
  input  resp_t resp_payload_i,
  input  logic resp_last_i,
  input  logic resp_valid_i,
  output logic resp_ready_o,
  output logic [NrPorts-1:0]
               [$clog2(MaxOutstanding+1)-1:0]
               outstanding_o,
  output logic busy_o
);

  localparam int unsigned IdxWidth =
    $clog2(NrPorts);
  localparam int unsigned CntWidth =
    $clog2(MaxOutstanding+1);
  localparam int unsigned PtrWidth =
    $clog2(RespDepth);
  localparam int unsigned FillWidth =
    $clog2(RespDepth+1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    BURST
  } state_e;

  state_e state_q, state_d;

  logic [IdxWidth-1:0]    ptr_q, ptr_d;
  logic [IdxWidth-1:0]    cur_q, cur_d;
  logic [WeightWidth-1:0] cnt_q, cnt_d;
  logic [WeightWidth-1:0] wgt_q, wgt_d;

  logic [NrPorts-1:0][CntWidth-1:0] outst_q;
  logic [NrPorts-1:0][CntWidth-1:0] outst_d;

  logic [IdxWidth-1:0]  mem_q [RespDepth];
  logic [IdxWidth-1:0]  mem_d [RespDepth];
  logic [PtrWidth-1:0]  wptr_q, wptr_d;
  logic [PtrWidth-1:0]  rptr_q, rptr_d;
  logic [FillWidth-1:0] fill_q, fill_d;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [NrPorts-1:0]     eligible;
  logic [IdxWidth-1:0]    pick_idx;
  logic                   pick_valid;
  logic [IdxWidth-1:0]    sel;
  logic [IdxWidth-1:0]    owner;
  logic [WeightWidth-1:0] wgt_sel;
  logic                   req_hs;
  logic                   push;
  logic                   pop;

  assign fifo_full  =
    (fill_q == FillWidth'(RespDepth));
  assign fifo_empty = (fill_q == '0);

  // Gated by reset so no request leaks out
  // combinationally while rst_ni is low.
  always_comb begin
    for (int i = 0; i < NrPorts; i++) begin
      eligible[i] = rst_ni
        & req_valid_i[i]
        & (weight_i[i] != '0)
        & (outst_q[i] <
           CntWidth'(MaxOutstanding))
        & ~fifo_full;
    end
  end

  snitch_wrr_pick #(
    .NrPorts (NrPorts)
  ) i_pick (
    .mask_i  (eligible),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    sel         = pick_idx;
    req_valid_o = pick_valid;
    unique case (state_q)
      HOLD: begin
        sel         = cur_q;
        req_valid_o = 1'b1;
      end
      BURST: begin
        sel         = cur_q;
        req_valid_o = eligible[cur_q];
      end
      default: ;
    endcase
  end

  assign req_payload_o = req_payload_i[sel];
  assign req_hs  = req_valid_o & req_ready_i;
  assign push    = req_hs;
  assign wgt_sel = (state_q == IDLE)
                 ? weight_i[sel] : wgt_q;

  always_comb begin
    req_ready_o      = '0;
    req_ready_o[sel] = req_valid_o & req_ready_i;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    wgt_d   = wgt_q;
    unique case (state_q)
      IDLE, HOLD: begin
        if (req_hs) begin
          if (wgt_sel == WeightWidth'(1)) begin
            state_d = IDLE;
            ptr_d   = sel;
          end else begin
            state_d = BURST;
            cur_d   = sel;
            wgt_d   = wgt_sel;
            cnt_d   = WeightWidth'(1);
          end
        end else if (state_q == IDLE
                     && req_valid_o) begin
          state_d = HOLD;
          cur_d   = sel;
          wgt_d   = wgt_sel;
        end
      end
      BURST: begin
        // A dropped requester forfeits the
        // remainder of its burst.
        if (!eligible[cur_q]) begin
          state_d = IDLE;
          ptr_d   = cur_q;
        end else if (req_hs) begin
          cnt_d = cnt_q + WeightWidth'(1);
          if (cnt_d == wgt_q) begin
            state_d = IDLE;
            ptr_d   = cur_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign owner = mem_q[rptr_q];

  assign resp_ready_o =
    resp_ready_i[owner] & ~fifo_empty;
  assign pop = resp_valid_i & resp_ready_o
             & resp_last_i;

  always_comb begin
    resp_valid_o = '0;
    if (!fifo_empty) begin
      resp_valid_o[owner] = resp_valid_i;
    end
  end

  assign resp_payload_o =
    {NrPorts{resp_payload_i}};
  assign resp_last_o = {NrPorts{resp_last_i}};

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    if (push) begin
      mem_d[wptr_q] = sel;
      wptr_d = (wptr_q ==
                PtrWidth'(RespDepth-1))
             ? '0 : wptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q ==
                PtrWidth'(RespDepth-1))
             ? '0 : rptr_q + PtrWidth'(1);
    end
    if (push && !pop) begin
      fill_d = fill_q + FillWidth'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - FillWidth'(1);
    end
  end

  always_comb begin
    outst_d = outst_q;
    for (int i = 0; i < NrPorts; i++) begin
      unique case ({
        push && sel == IdxWidth'(i),
        pop && owner == IdxWidth'(i)})
        2'b10:
          outst_d[i] = outst_q[i]
                     + CntWidth'(1);
        2'b01:
          outst_d[i] = outst_q[i]
                     - CntWidth'(1);
        default: ;
      endcase
    end
  end

  assign outstanding_o = outst_q;
  assign busy_o = (|outst_q)
                | (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= IdxWidth'(NrPorts-1);
      cur_q   <= '0;
      cnt_q   <= '0;
      wgt_q   <= '0;
      outst_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      for (int i = 0; i < RespDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      wgt_q   <= wgt_d;
      outst_q <= outst_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fill_q  <= fill_d;
      mem_q   <= mem_d;
    end
  end

  a_hold_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    state_q == HOLD |-> req_valid_i[cur_q]);

  a_resp_owner: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    resp_valid_i |-> !fifo_empty);

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    push |-> outst_q[sel] !=
      CntWidth'(MaxOutstanding));

  a_no_underflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    pop |-> outst_q[owner] != '0);

endmodule

// File: tb/tb_snitch_wrr_scheduler.sv
// Directed bench for the weighted round-robin
// scheduler: grants, bursts, caps, routing, reset.
module tb_snitch_wrr_scheduler;
  import snitch_wrr_scheduler_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [3:0][3:0] weight_i;
  dreq_t [3:0] req_payload_i;
  logic [3:0] req_valid_i;
  logic [3:0] req_ready_o;
  dresp_t [3:0] resp_payload_o;
  logic [3:0] resp_last_o;
  logic [3:0] resp_valid_o;
  logic [3:0] resp_ready_i;
  dreq_t req_payload_o;
  logic req_valid_o;
  logic req_ready_i;
  dresp_t resp_payload_i;
  logic resp_last_i;
  logic resp_valid_i;
  logic resp_ready_o;
  logic [3:0][2:0] outstanding_o;
  logic busy_o;

  int n_run  = 0;
  int n_fail = 0;
  int q[$];
  int exp1[10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
  int exp5[6]  = '{3, 3, 1, 1, 3, 3};

  snitch_wrr_scheduler dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .weight_i       (weight_i),
    .req_payload_i  (req_payload_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .resp_payload_o (resp_payload_o),
    .resp_last_o    (resp_last_o),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .req_payload_o  (req_payload_o),
    .req_valid_o    (req_valid_o),
    .req_ready_i    (req_ready_i),
    .resp_payload_i (resp_payload_i),
    .resp_last_i    (resp_last_i),
    .resp_valid_i   (resp_valid_i),
    .resp_ready_o   (resp_ready_o),
    .outstanding_o  (outstanding_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string tag);
    while (q.size() != 0) begin
      resp_valid_i = 1'b1;
      resp_last_i  = 1'b1;
      #1;
      chk(tag, resp_valid_o, 64'(1 << q[0]));
      @(posedge clk_i);
      void'(q.pop_front());
      #1;
    end
    resp_valid_i = 1'b0;
  endtask

  task automatic grant(
    input string tag,
    input int    port
  );
    #1;
    chk(tag, req_ready_o, 64'(1 << port));
    @(posedge clk_i);
    q.push_back(port);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni       = 1'b0;
    weight_i     = '{4'd1, 4'd3, 4'd2, 4'd1};
    req_valid_i  = '0;
    req_ready_i  = 1'b1;
    resp_ready_i = 4'hf;
    resp_valid_i = 1'b0;
    resp_last_i  = 1'b1;
    resp_payload_i = '{data: 32'hcafe_f00d,
                       error: 1'b0};
    for (int i = 0; i < 4; i++) begin
      req_payload_i[i].addr  = 32'(i);
      req_payload_i[i].data  = 32'h1000 + 32'(i);
      req_payload_i[i].strb  = 4'hf;
      req_payload_i[i].write = 1'b0;
    end

    #2;
    chk("rst_req_valid", req_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_ready", resp_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_outst", outstanding_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // weights {1,2,3,1}, one-cycle responses
    req_valid_i = 4'hf;
    for (int c = 0; c < 10; c++) begin
      resp_valid_i = (q.size() != 0);
      #1;
      chk("t1_grant", req_ready_o,
          64'(1 << exp1[c]));
      chk("t1_payload", req_payload_o.addr,
          64'(exp1[c]));
      if (q.size() != 0)
        chk("t1_rvalid", resp_valid_o,
            64'(1 << q[0]));
      @(posedge clk_i);
      if (resp_valid_i) void'(q.pop_front());
      q.push_back(exp1[c]);
      #1;
    end
    req_valid_i = '0;
    drain("t1_drain");
    #1;
    chk("t1_idle_busy", busy_o, 0);
    chk("t1_idle_outst", outstanding_o, 0);

    // burst forfeited by port 2
    req_valid_i = 4'b1100;
    grant("t2_g2", 2);
    req_valid_i = 4'b1000;
    #1;
    chk("t2_bubble", req_valid_o, 0);
    chk("t2_busy", busy_o, 1);
    tick();
    grant("t2_g3", 3);
    req_valid_i = 4'hf;
    grant("t2_wrap0", 0);
    req_valid_i = '0;
    drain("t2_resp");

    // outstanding cap on port 0
    req_valid_i = 4'b0001;
    for (int k = 0; k < 4; k++)
      grant("t3_fill", 0);
    #1;
    chk("t3_capped", req_valid_o, 0);
    chk("t3_out4", outstanding_o[0], 4);
    resp_valid_i = 1'b1;
    resp_last_i  = 1'b1;
    #1;
    chk("t3_still_capped", req_valid_o, 0);
    @(posedge clk_i);
    void'(q.pop_front());
    #1;
    resp_valid_i = 1'b0;
    #1;
    chk("t3_out3", outstanding_o[0], 3);
    grant("t3_one_more", 0);
    #1;
    chk("t3_recapped", req_valid_o, 0);
    chk("t3_out4b", outstanding_o[0], 4);
    req_valid_i = '0;
    drain("t3_resp");

    // downstream stall holds port 1
    req_ready_i = 1'b0;
    req_valid_i = 4'b0010;
    #1;
    chk("t4_valid", req_valid_o, 1);
    chk("t4_sel", req_payload_o.addr, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      req_valid_i = 4'b0011;
      #1;
      chk("t4_hold", req_payload_o.addr, 1);
      tick();
    end
    req_ready_i = 1'b1;
    grant("t4_accept1", 1);
    grant("t4_burst1", 1);
    grant("t4_then0", 0);
    weight_i[0] = 4'd0;
    req_valid_i = 4'b0001;
    #1;
    chk("t4_masked", req_valid_o, 0);
    weight_i[0] = 4'd1;
    req_valid_i = '0;
    drain("t4_resp");

    // two-beat responses 3,1,3
    weight_i[1] = 4'd1;
    req_valid_i = 4'b1000;
    grant("t5_g3a", 3);
    req_valid_i = 4'b0010;
    grant("t5_g1", 1);
    req_valid_i = 4'b1000;
    grant("t5_g3b", 3);
    req_valid_i = '0;
    for (int b = 0; b < 6; b++) begin
      resp_valid_i = 1'b1;
      resp_last_i  = (b % 2) == 1;
      #1;
      chk("t5_route", resp_valid_o,
          64'(1 << exp5[b]));
      chk("t5_last", resp_last_o,
          resp_last_i ? 64'hf : 64'h0);
      if (b == 0)
        chk("t5_bcast", resp_payload_o[2],
            64'(resp_payload_i));
      tick();
      if (b == 0)
        chk("t5_no_pop", outstanding_o[3], 2);
      if (b == 1)
        chk("t5_pop", outstanding_o[3], 1);
    end
    q.delete();
    resp_valid_i = 1'b0;
    resp_last_i  = 1'b1;
    chk("t5_empty", outstanding_o, 0);
    weight_i[1] = 4'd2;

    // reset in the middle of a burst
    req_valid_i = 4'b0100;
    grant("t6_g2a", 2);
    grant("t6_g2b", 2);
    chk("t6_out2", outstanding_o[2], 2);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", req_valid_o, 0);
    chk("t6_rst_ready", req_ready_o, 0);
    chk("t6_rst_rready", resp_ready_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_outst", outstanding_o, 0);
    q.delete();
    tick();
    rst_ni = 1'b1;
    req_valid_i = 4'hf;
    grant("t6_first0", 0);
    req_valid_i = '0;
    drain("t6_resp");

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
